// File: rtl/alu_control_muldiv.sv
// rtl/alu_control_muldiv.sv - ALU operation decoder with iterative multiply/divide unit and HI/LO registers
module alu_control_muldiv #(
    parameter int WIDTH = 32,
    parameter int OPW   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       ALUOp,
    input  logic [5:0]       functField,
    input  logic             valid,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic [OPW-1:0]   Operation,
    output logic             stall,
    output logic             busy,
    output logic             mf_valid,
    output logic [WIDTH-1:0] mf_result,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX
    } state_t;

    state_t state, state_nx;

    logic [3:0]       op4;
    logic             rtype;
    logic             is_mult, is_multu, is_div, is_divu, is_mfhi, is_mflo;
    logic             is_muldiv, idle, accept;
    logic             rs_neg, rt_neg;
    logic [WIDTH-1:0] rs_mag, rt_mag;

    logic [CW-1:0]    cnt;
    logic             op_div, neg_q, neg_r;
    logic [WIDTH-1:0] acc, wlo, b;
    logic [WIDTH-1:0] hi, lo;
    logic             dbz;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_try;
    logic [WIDTH-1:0]   div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    always_comb begin
        op4 = 4'b0000;
        case (ALUOp)
            2'b00: op4 = 4'b0010;
            2'b01: op4 = 4'b0110;
            2'b10: begin
                case (functField)
                    6'b100000: op4 = 4'b0010;
                    6'b100010: op4 = 4'b0110;
                    6'b100100: op4 = 4'b0000;
                    6'b100101: op4 = 4'b0001;
                    6'b100111: op4 = 4'b1100;
                    6'b101010: op4 = 4'b0111;
                    default:   op4 = 4'b0000;
                endcase
            end
            default: begin
                case (functField[3:0])
                    4'b0010: op4 = 4'b0110;
                    4'b1010: op4 = 4'b0111;
                    default: op4 = 4'b0000;
                endcase
            end
        endcase
    end

    assign Operation = OPW'(op4);

    assign rtype     = (ALUOp == 2'b10);
    assign is_mult   = rtype && (functField == 6'b011000);
    assign is_multu  = rtype && (functField == 6'b011001);
    assign is_div    = rtype && (functField == 6'b011010);
    assign is_divu   = rtype && (functField == 6'b011011);
    assign is_mfhi   = rtype && (functField == 6'b010000);
    assign is_mflo   = rtype && (functField == 6'b010010);
    assign is_muldiv = is_mult | is_multu | is_div | is_divu;

    assign idle   = (state == S_IDLE);
    assign busy   = ~idle;
    assign stall  = valid & (is_muldiv | is_mfhi | is_mflo) & ~idle;
    assign accept = valid & is_muldiv & idle;

    assign mf_valid    = valid & (is_mfhi | is_mflo) & idle;
    assign mf_result   = mf_valid ? (is_mfhi ? hi : lo) : '0;
    assign div_by_zero = dbz;

    // The core always works on magnitudes; signs are re-applied in FIX.
    assign rs_neg = (is_mult | is_div) & rs_val[WIDTH-1];
    assign rt_neg = (is_mult | is_div) & rt_val[WIDTH-1];
    assign rs_mag = rs_neg ? -rs_val : rs_val;
    assign rt_mag = rt_neg ? -rt_val : rt_val;

    assign mul_sum  = {1'b0, acc} + {1'b0, (wlo[0] ? b : {WIDTH{1'b0}})};
    assign div_try  = {acc, wlo[WIDTH-1]};
    assign div_ge   = (div_try >= {1'b0, b});
    assign div_diff = div_try[WIDTH-1:0] - b;

    assign prod     = {acc, wlo};
    assign prod_fix = neg_q ? -prod : prod;
    assign quo_fix  = neg_q ? -wlo : wlo;
    assign rem_fix  = neg_r ? -acc : acc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (accept) state_nx = S_RUN;
            S_RUN:   if (cnt == CW'(WIDTH - 1)) state_nx = S_FIX;
            S_FIX:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt    <= '0;
            op_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            acc    <= '0;
            wlo    <= '0;
            b      <= '0;
            hi     <= '0;
            lo     <= '0;
            dbz    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        cnt    <= '0;
                        op_div <= is_div | is_divu;
                        neg_q  <= rs_neg ^ rt_neg;
                        neg_r  <= rs_neg;
                        acc    <= '0;
                        wlo    <= rs_mag;
                        b      <= rt_mag;
                        dbz    <= (is_div | is_divu) & (rt_val == '0);
                    end
                end
                S_RUN: begin
                    cnt <= cnt + 1'b1;
                    if (op_div) begin
                        // A zero divisor always "fits", giving all-ones quotient and remainder = dividend.
                        acc <= div_ge ? div_diff : div_try[WIDTH-1:0];
                        wlo <= {wlo[WIDTH-2:0], div_ge};
                    end else begin
                        acc <= mul_sum[WIDTH:1];
                        wlo <= {mul_sum[0], wlo[WIDTH-1:1]};
                    end
                end
                S_FIX: begin
                    if (op_div) begin
                        lo <= quo_fix;
                        hi <= rem_fix;
                    end else begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_control_muldiv.sv
// tb/tb_alu_control_muldiv.sv - scoreboard bench for alu_control_muldiv against a plain-arithmetic model
module tb_alu_control_muldiv;

    localparam int W = 32;

    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;

    logic         clk = 1'b0;
    logic         reset;
    logic [1:0]   ALUOp;
    logic [5:0]   functField;
    logic         valid;
    logic [W-1:0] rs_val, rt_val;
    logic [3:0]   Operation;
    logic         stall, busy, mf_valid, div_by_zero;
    logic [W-1:0] mf_result;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] sb[$];
    logic [W-1:0] m_hi, m_lo;
    logic         m_dbz;

    alu_control_muldiv #(.WIDTH(W), .OPW(4)) dut (
        .clk(clk), .reset(reset), .ALUOp(ALUOp), .functField(functField), .valid(valid),
        .rs_val(rs_val), .rt_val(rt_val), .Operation(Operation), .stall(stall), .busy(busy),
        .mf_valid(mf_valid), .mf_result(mf_result), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] ref_op(input logic [1:0] a, input logic [5:0] f);
        logic [3:0] r;
        r = 4'b0000;
        if (a == 2'b00) r = 4'b0010;
        else if (a == 2'b01) r = 4'b0110;
        else if (a == 2'b10) begin
            if (f == 6'h20) r = 4'b0010;
            else if (f == 6'h22) r = 4'b0110;
            else if (f == 6'h25) r = 4'b0001;
            else if (f == 6'h27) r = 4'b1100;
            else if (f == 6'h2A) r = 4'b0111;
        end else begin
            if (f[3:0] == 4'h2) r = 4'b0110;
            else if (f[3:0] == 4'hA) r = 4'b0111;
        end
        return r;
    endfunction

    task automatic model(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] bv,
                         output logic [W-1:0] hi, output logic [W-1:0] lo, output logic dz);
        longint p;
        int sa, sbv;
        logic [63:0] up;
        logic [W-1:0] q, r;
        sa = a; sbv = bv;
        dz = 1'b0; hi = '0; lo = '0;
        if (f == F_MULT) begin
            p = longint'(sa) * longint'(sbv);
            {hi, lo} = p;
        end else if (f == F_MULTU) begin
            up = {32'd0, a} * {32'd0, bv};
            {hi, lo} = up;
        end else if (f == F_DIV) begin
            dz = (bv == 0);
            if (bv == 0) begin
                q = '1;
                r = a[W-1] ? -a : a;
                if (a[W-1]) begin q = -q; r = -r; end
            end else if (a == 32'h80000000 && bv == 32'hFFFFFFFF) begin
                q = 32'h80000000; r = 0;
            end else begin
                q = sa / sbv; r = sa % sbv;
            end
            lo = q; hi = r;
        end else begin
            dz = (bv == 0);
            if (bv == 0) begin lo = '1; hi = a; end
            else begin lo = a / bv; hi = a % bv; end
        end
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h80000000;
            2: return 32'hFFFFFFFF;
            3: return 32'($urandom_range(0, 15));
            default: return 32'($urandom);
        endcase
    endfunction

    // monitor: every mf_valid cycle must match the oldest expected HI/LO read
    always @(negedge clk) begin
        if (mf_valid) begin
            if (sb.size() == 0) chk("mf_unexpected", 64'(mf_result), 64'hDEAD);
            else chk("mf_result", 64'(mf_result), 64'(sb.pop_front()));
        end
    end

    task automatic present(input logic [1:0] a, input logic [5:0] f, input logic [W-1:0] x, input logic [W-1:0] y);
        valid = 1'b1; ALUOp = a; functField = f; rs_val = x; rt_val = y;
    endtask

    task automatic run_op(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] bv);
        logic [W-1:0] nh, nl;
        logic nd;
        int n;
        model(f, a, bv, nh, nl, nd);
        present(2'b10, f, a, bv);
        @(negedge clk);
        chk("accept_stall", 64'(stall), 0);
        @(posedge clk); #1 valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (busy && n < 200) begin n++; @(negedge clk); end
        chk("occupancy", 64'(n + 1), 64'(W + 2));
        m_hi = nh; m_lo = nl; m_dbz = nd;
        chk("div_by_zero", 64'(div_by_zero), 64'(m_dbz));
        @(posedge clk); #1;
    endtask

    task automatic do_mf(input logic sel_hi, input int exp_stalls);
        int n;
        sb.push_back(sel_hi ? m_hi : m_lo);
        present(2'b10, sel_hi ? F_MFHI : F_MFLO, pick(), pick());
        n = 0;
        @(negedge clk);
        while (stall && n < 200) begin n++; @(negedge clk); end
        chk("mf_stall_cycles", 64'(n), 64'(exp_stalls));
        @(posedge clk); #1 valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] nh, nl;
        logic nd;
        logic [5:0] f;
        logic [1:0] a;
        int n;
        reset = 1'b1; valid = 1'b0; ALUOp = 2'b00; functField = '0; rs_val = '0; rt_val = '0;
        m_hi = '0; m_lo = '0; m_dbz = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_dbz", 64'(div_by_zero), 0);
        chk("rst_stall", 64'(stall), 0);
        chk("rst_mf_valid", 64'(mf_valid), 0);
        @(posedge clk); #1 reset = 1'b0;
        do_mf(1'b1, 0);
        do_mf(1'b0, 0);

        // decode sweep, valid low so no op launches
        for (int i = 0; i < 256; i++) begin
            ALUOp = 2'(i >> 6); functField = 6'(i);
            @(negedge clk);
            chk("decode", 64'(Operation), 64'(ref_op(ALUOp, functField)));
            @(posedge clk); #1;
        end

        // directed boundary cases
        run_op(F_MULT, 32'hFFFFFFFF, 32'h2);
        chk("mult_hi_const", 64'(m_hi), 64'hFFFFFFFF);
        do_mf(1'b1, 0); do_mf(1'b0, 0);
        run_op(F_MULTU, 32'hFFFFFFFF, 32'h2);
        chk("multu_hi_const", 64'(m_hi), 64'h1);
        do_mf(1'b1, 0); do_mf(1'b0, 0);
        run_op(F_DIV, 32'hFFFFFFF9, 32'h2);
        do_mf(1'b1, 0); do_mf(1'b0, 0);
        run_op(F_DIVU, 32'h7, 32'h0);
        do_mf(1'b1, 0); do_mf(1'b0, 0);
        run_op(F_DIV, 32'h80000000, 32'hFFFFFFFF);
        do_mf(1'b1, 0); do_mf(1'b0, 0);

        // mflo one cycle after mult: stalled through RUN and FIX
        rs_val = pick();
        model(F_MULT, 32'h12345678, 32'hFEDCBA98, nh, nl, nd);
        present(2'b10, F_MULT, 32'h12345678, 32'hFEDCBA98);
        @(posedge clk); #1 valid = 1'b0;
        m_hi = nh; m_lo = nl; m_dbz = nd;
        do_mf(1'b0, W + 1);
        do_mf(1'b1, 0);

        // non-mul/div instruction during busy never stalls
        run_op(F_DIVU, 32'h0, 32'h0);
        present(2'b10, F_DIVU, 32'h9, 32'h3);
        model(F_DIVU, 32'h9, 32'h3, nh, nl, nd);
        @(posedge clk); #1;
        present(2'b00, 6'($urandom), pick(), pick());
        @(negedge clk);
        chk("add_busy_stall", 64'(stall), 0);
        chk("add_busy_op", 64'(Operation), 64'h2);
        chk("busy_in_run", 64'(busy), 1);
        @(posedge clk); #1 valid = 1'b0;
        n = 0;
        while (busy && n < 200) begin n++; @(posedge clk); #1; end
        m_hi = nh; m_lo = nl; m_dbz = nd;
        chk("dbz_cleared", 64'(div_by_zero), 0);
        do_mf(1'b1, 0); do_mf(1'b0, 0);

        // randomized ops
        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 3))
                0: f = F_MULT;
                1: f = F_MULTU;
                2: f = F_DIV;
                default: f = F_DIVU;
            endcase
            run_op(f, pick(), pick());
            do_mf(1'b1, 0);
            do_mf(1'b0, 0);
            a = 2'($urandom); f = 6'($urandom);
            ALUOp = a; functField = f;
            @(negedge clk);
            chk("decode_rand", 64'(Operation), 64'(ref_op(a, f)));
            @(posedge clk); #1;
        end

        // reset in the middle of RUN
        run_op(F_DIVU, 32'h7, 32'h0);
        present(2'b10, F_MULT, 32'hFFFFFFFF, 32'h2);
        @(posedge clk); #1 valid = 1'b0;
        repeat (10) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("rst_mid_busy", 64'(busy), 0);
        chk("rst_mid_dbz", 64'(div_by_zero), 0);
        @(posedge clk); #1 reset = 1'b0;
        m_hi = '0; m_lo = '0; m_dbz = 1'b0;
        do_mf(1'b1, 0);
        do_mf(1'b0, 0);

        repeat (3) @(posedge clk);
        chk("scoreboard_empty", 64'(sb.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
